// File: rtl/loader_pkg.sv
// Shared types and constants for the switch-driven data-memory loader.
// The optional auto-increment feature is selected with LOADER_AUTOINC_EN.
package loader_pkg;

  // Loader operating mode: LOAD lets switches fill memory, RUN hands over to the core.
  typedef enum logic [0:0] {
    ST_LOAD = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  localparam int DMEM_DATA_W = 32;
  localparam int SW_DATA_W   = 8;

  // Bit positions of the four debounced control inputs.
  localparam int EV_NEXT  = 0;
  localparam int EV_PREV  = 1;
  localparam int EV_WRITE = 2;
  localparam int EV_START = 3;
  localparam int EV_NUM   = 4;

endpackage

// File: rtl/sw_debounce.sv
// Two-flop synchroniser, stability counter and edge-event generator for one
// raw board input. The debounced level only changes after DEBOUNCE_CYCLES
// consecutive synchronised samples disagree with it.
module sw_debounce #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync2_q;
  logic             level_q, level_d;
  logic             level_dly_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;

  // Count disagreeing samples; the last one flips the level and restarts the count.
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = ~level_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
    rise_d = level_q & ~level_dly_q;
    fall_d = ~level_q & level_dly_q;
  end

  // Synchroniser, debounce state and registered edge events.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      level_q     <= 1'b0;
      level_dly_q <= 1'b0;
      cnt_q       <= '0;
      rise_q      <= 1'b0;
      fall_q      <= 1'b0;
    end else begin
      sync1_q     <= raw_i;
      sync2_q     <= sync1_q;
      level_q     <= level_d;
      level_dly_q <= level_q;
      cnt_q       <= cnt_d;
      rise_q      <= rise_d;
      fall_q      <= fall_d;
    end
  end

  assign level_o = level_q;
  assign rise_o  = rise_q;
  assign fall_o  = fall_q;

endmodule

// File: rtl/switch_dmem_loader.sv
// Board-switch front end for the RV32I data memory: debounces the controls,
// keeps a word pointer, issues write strobes in LOAD and the start handshake.
// Define LOADER_AUTOINC_EN to make every accepted write also advance the pointer.
module switch_dmem_loader
  import loader_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int ADDR_W          = 5
) (
  input  logic                   clk_100mhz,
  input  logic                   i_rst_n,
  input  logic                   pulse_next_sw,
  input  logic                   pulse_prev_sw,
  input  logic                   Wen_top,
  input  logic                   start,
  input  logic [SW_DATA_W-1:0]   Wdata_top,
  output logic                   dmem_we,
  output logic [DMEM_DATA_W-1:0] dmem_addr,
  output logic [DMEM_DATA_W-1:0] dmem_wdata,
  output logic [ADDR_W-1:0]      cur_idx,
  output logic [ADDR_W:0]        wr_count,
  output logic                   cpu_start,
  output logic                   run
);

  localparam logic [ADDR_W:0] WR_MAX = {1'b1, {ADDR_W{1'b0}}};

  logic [EV_NUM-1:0] raw_vec;
  logic [EV_NUM-1:0] level_vec;
  logic [EV_NUM-1:0] rise_vec;
  logic [EV_NUM-1:0] fall_vec;

  assign raw_vec[EV_NEXT]  = pulse_next_sw;
  assign raw_vec[EV_PREV]  = pulse_prev_sw;
  assign raw_vec[EV_WRITE] = Wen_top;
  assign raw_vec[EV_START] = start;

  genvar gi;
  generate
    for (gi = 0; gi < EV_NUM; gi++) begin : g_deb
      sw_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_deb (
        .clk    (clk_100mhz),
        .rst_n  (i_rst_n),
        .raw_i  (raw_vec[gi]),
        .level_o(level_vec[gi]),
        .rise_o (rise_vec[gi]),
        .fall_o (fall_vec[gi])
      );
    end
  endgenerate

  // Data switches are only synchronised; they are settled long before a write fires.
  logic [SW_DATA_W-1:0] wsync1_q, wsync2_q;

  state_e                 state_q, state_d;
  logic [ADDR_W-1:0]      idx_q, idx_d;
  logic [ADDR_W:0]        wr_count_q, wr_count_d;
  logic                   we_q, we_d;
  logic [DMEM_DATA_W-1:0] addr_q, addr_d;
  logic [DMEM_DATA_W-1:0] wdata_q, wdata_d;
  logic                   cpu_start_q, cpu_start_d;
  logic                   wr_acc;
  logic                   inc;
  logic                   dec;

  // Next-state for the mode FSM, pointer, write register and write counter.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    wr_count_d  = wr_count_q;
    we_d        = 1'b0;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    cpu_start_d = 1'b0;

    wr_acc = rise_vec[EV_WRITE] && (state_q == ST_LOAD);
`ifdef LOADER_AUTOINC_EN
    // A write and a next together still move the pointer by a single word.
    inc = rise_vec[EV_NEXT] | wr_acc;
`else
    inc = rise_vec[EV_NEXT];
`endif
    dec = rise_vec[EV_PREV];

    // Write uses the pointer value from before any move in this cycle.
    if (wr_acc) begin
      we_d    = 1'b1;
      addr_d  = {{(DMEM_DATA_W-ADDR_W-2){1'b0}}, idx_q, 2'b00};
      wdata_d = {{(DMEM_DATA_W-SW_DATA_W){1'b0}}, wsync2_q};
      if (wr_count_q != WR_MAX) begin
        wr_count_d = wr_count_q + 1'b1;
      end
    end

    // Pointer wraps naturally at the ADDR_W boundary.
    if (inc && !dec) begin
      idx_d = idx_q + 1'b1;
    end else if (dec && !inc) begin
      idx_d = idx_q - 1'b1;
    end

    case (state_q)
      ST_LOAD: begin
        if (rise_vec[EV_START]) begin
          state_d     = ST_RUN;
          cpu_start_d = 1'b1;
        end
      end
      ST_RUN: begin
        if (fall_vec[EV_START]) begin
          state_d = ST_LOAD;
        end
      end
      default: state_d = ST_LOAD;
    endcase
  end

  // State registers; reset clears everything including any pending strobe.
  always_ff @(posedge clk_100mhz or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wsync1_q    <= '0;
      wsync2_q    <= '0;
      state_q     <= ST_LOAD;
      idx_q       <= '0;
      wr_count_q  <= '0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      cpu_start_q <= 1'b0;
    end else begin
      wsync1_q    <= Wdata_top;
      wsync2_q    <= wsync1_q;
      state_q     <= state_d;
      idx_q       <= idx_d;
      wr_count_q  <= wr_count_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      cpu_start_q <= cpu_start_d;
    end
  end

  assign dmem_we    = we_q;
  assign dmem_addr  = addr_q;
  assign dmem_wdata = wdata_q;
  assign cur_idx    = idx_q;
  assign wr_count   = wr_count_q;
  assign cpu_start  = cpu_start_q;
  assign run        = (state_q == ST_RUN);

endmodule
